bldc_trace_capture: RTL and testbench
=====================================

Name: bldc_trace_capture

Overview:
- Parametrised on-chip trace buffer for the brushless driver's debug signals (duty, rotateState, HIN_x/_LIN_x and similar).
- Samples a CH_W-bit probe bus on a qualified sample strobe and holds a programmable number of pre-trigger samples. It triggers on a masked value or edge match, fills the rest of the buffer, then freezes it for readback.
- Sits beside the motor control logic and is read out by the UART/debug front end.
- Unlike a fixed vendor analyzer core, it has runtime pre-trigger length, edge/level trigger modes, force-trigger and abort.

Parameters:
- CH_W, 10: probe bus width in bits.
- DEPTH_LOG2, 10: log2 of buffer depth; DEPTH = 2**DEPTH_LOG2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- sample_en_i  in  1  sample strobe, one clk_i cycle wide (for example a divided-counter tick).
- probe_i  in  CH_W  signals to capture.
- arm_i  in  1  pulse: start a new capture.
- abort_i  in  1  pulse: return to IDLE.
- force_trig_i  in  1  pulse: trigger unconditionally (honoured only in WAIT_TRIG).
- pre_len_i  in  DEPTH_LOG2  pre-trigger sample count; latched at arm.
- trig_val_i  in  CH_W  trigger compare value.
- trig_mask_i  in  CH_W  1 = bit participates in the compare.
- trig_edge_i  in  1  0 = level match, 1 = match on entry only.
- rd_addr_i  in  DEPTH_LOG2  logical read index; 0 = oldest sample.
- rd_data_o  out  CH_W  buffer data, valid 1 cycle after rd_addr_i.
- busy_o  out  1  capture in progress (PRE, WAIT_TRIG, POST).
- triggered_o  out  1  trigger has occurred this capture.
- done_o  out  1  buffer frozen and readable.

Behaviour:
- Reset: state = IDLE; all pointers and counters 0; busy_o, triggered_o, done_o = 0; rd_data_o = 0. Buffer contents are undefined.
- The FSM has five states: IDLE, PRE, WAIT_TRIG, POST, DONE.
- A sample is "taken" when sample_en_i = 1 in PRE, WAIT_TRIG or POST. probe_i is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pre-trigger length:
  - pre_q = min(pre_len_i, DEPTH-1), latched on arm.
  - post_q = DEPTH-1-pre_q.
- Arming:
  - arm_i in IDLE or DONE: wr_ptr = 0, pre_cnt = 0, clear triggered_o/done_o, clear prev_match.
  - Next state is PRE, or WAIT_TRIG directly if pre_q = 0.
  - arm_i in any other state is ignored.
- PRE:
  - Each taken sample increments pre_cnt.
  - When pre_cnt reaches pre_q, go to WAIT_TRIG.
  - Trigger matches in PRE are ignored, but prev_match is still updated.
- Trigger match: match = (((probe_i ^ trig_val_i) & trig_mask_i) == 0).
  - Level mode fires on match. A mask of 0 fires on the first WAIT_TRIG sample.
  - Edge mode fires on match && !prev_match. prev_match updates on every taken sample.
- WAIT_TRIG:
  - Samples continue circularly.
  - The firing condition is evaluated only on taken samples, or on force_trig_i in any cycle.
  - On a sample that fires, that sample is written. trig_ptr = its address, triggered_o = 1.
  - On force_trig_i without a sample, trig_ptr = wr_ptr-1, so the last written sample is the trigger point.
  - Then post_cnt = 0 and state = POST. If post_q = 0, go straight to DONE.
- POST:
  - Each taken sample increments post_cnt.
  - When post_cnt reaches post_q, go to DONE on the same edge as the final write.
- DONE:
  - done_o = 1, busy_o = 0, no writes.
  - start_ptr = trig_ptr - pre_q (mod DEPTH).
- Readout:
  - Physical address = start_ptr + rd_addr_i (mod DEPTH).
  - rd_data_o is registered, with 1-cycle latency, in all states.
  - Logical index pre_q is always the trigger sample.
- abort_i: from any state go to IDLE; clear busy_o and done_o, hold triggered_o.
- Simultaneous events (priority): abort_i > arm_i > force_trig_i > sample-based trigger.
- Reset mid-capture returns to IDLE immediately (asynchronous assertion). Reset deassertion needs no special sequencing beyond the team's standard synchroniser.
- All pointer arithmetic is DEPTH_LOG2 bits wide and wraps naturally; counters never exceed DEPTH-1.

Decomposition:
- Shared package bldc_dbg_pkg holds:
  - the state enum trace_state_t {IDLE, PRE, WAIT_TRIG, POST, DONE};
  - the default CH_W/DEPTH_LOG2 constants;
  - the probe bus bit-position constants (DUTY_BIT, ROT_LSB, HIN_LSB, LIN_LSB).
- Sub-module trace_ram: simple dual-port, one write port, registered read port, DEPTH x CH_W, inferred to block SRAM.
- The FSM, pointers and trigger compare stay in bldc_trace_capture.

Test Plan:
- Reset check: with DEPTH_LOG2 = 4, hold rst_i mid-POST -> busy_o = triggered_o = done_o = 0 immediately, and state is IDLE after release.
- Level trigger, wrap-around: DEPTH_LOG2 = 4, pre_len = 5, mask = 0x3FF, val = 0x07F; probe counts 0,1,2,... on every sample_en_i. The counter reaches 0x07F only after 127 samples, so wr_ptr has wrapped many times. Expected: done_o after 10 further samples; rd_addr 5 -> 0x07F, rd_addr 0 -> 0x07A, rd_addr 15 -> 0x089.
- Edge mode: mask = 0x001, val = 0x001, probe bit0 held at 1 before arm and through PRE. Expected: no trigger while it stays high. On a 0->1 transition, trigger with triggered_o = 1, and the trigger sample sits at rd_addr = pre_len.
- Force trigger: pre_len = 0, mask matching nothing, force_trig_i asserted after 3 samples. Expected: rd_addr 0 = 3rd sample, and done_o after 15 more samples.
- Simultaneous and boundary cases:
  - arm_i with abort_i in the same cycle -> IDLE.
  - pre_len = 0xF with DEPTH = 16 -> clamped to 15; done_o on the trigger sample; rd_addr 15 = trigger.
  - arm_i during POST -> ignored, capture completes unchanged.

Source files
------------

// File: rtl/bldc_dbg_pkg.sv
// rtl/bldc_dbg_pkg.sv - shared types and constants for the BLDC debug trace capture
package bldc_dbg_pkg;

  localparam int CH_W_DEF       = 10;
  localparam int DEPTH_LOG2_DEF = 10;

  // Probe bus layout: PWM duty, 3-bit rotateState, HIN_x[2:0], LIN_x[2:0]
  localparam int DUTY_BIT = 0;
  localparam int ROT_LSB  = 1;
  localparam int HIN_LSB  = 4;
  localparam int LIN_LSB  = 7;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } trace_state_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port DEPTH x CH_W trace store with registered read port
module trace_ram #(
  parameter int CH_W       = 10,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [CH_W-1:0]       wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [CH_W-1:0]       rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [CH_W-1:0] mem [DEPTH];
  logic [CH_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset, so the array itself still maps to block SRAM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bldc_trace_capture.sv
// rtl/bldc_trace_capture.sv - pre/post-trigger capture of the BLDC driver probe bus
module bldc_trace_capture
  import bldc_dbg_pkg::*;
#(
  parameter int CH_W       = CH_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sample_en_i,
  input  logic [CH_W-1:0]       probe_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic                  force_trig_i,
  input  logic [DEPTH_LOG2-1:0] pre_len_i,
  input  logic [CH_W-1:0]       trig_val_i,
  input  logic [CH_W-1:0]       trig_mask_i,
  input  logic                  trig_edge_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [CH_W-1:0]       rd_data_o,
  output logic                  busy_o,
  output logic                  triggered_o,
  output logic                  done_o
);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  trace_state_t state_q, state_d;
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t pre_cnt_q, pre_cnt_d;
  ptr_t post_cnt_q, post_cnt_d;
  ptr_t pre_q, pre_d;
  ptr_t trig_ptr_q, trig_ptr_d;
  logic triggered_q, triggered_d;
  logic prev_match_q, prev_match_d;

  ptr_t post_len, start_ptr, rd_phys, wr_inc, pre_inc, post_inc;
  logic capturing, take, match, fire;

  assign capturing = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign take      = capturing && sample_en_i && !abort_i;
  assign match     = ((probe_i ^ trig_val_i) & trig_mask_i) == '0;
  assign fire      = take && match && !(trig_edge_i && prev_match_q);

  // DEPTH-1-pre in DEPTH_LOG2 bits is just the complement
  assign post_len  = ~pre_q;
  assign start_ptr = trig_ptr_q - pre_q;
  assign rd_phys   = start_ptr + rd_addr_i;
  assign wr_inc    = wr_ptr_q + 1'b1;
  assign pre_inc   = pre_cnt_q + 1'b1;
  assign post_inc  = post_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    pre_d        = pre_q;
    trig_ptr_d   = trig_ptr_q;
    triggered_d  = triggered_q;
    prev_match_d = prev_match_q;

    if (take) begin
      wr_ptr_d     = wr_inc;
      prev_match_d = match;
    end

    if (abort_i) begin
      state_d = IDLE;
    end else if (arm_i && ((state_q == IDLE) || (state_q == DONE))) begin
      // pre_len_i is DEPTH_LOG2 wide, so it can never exceed DEPTH-1
      pre_d        = pre_len_i;
      wr_ptr_d     = '0;
      pre_cnt_d    = '0;
      post_cnt_d   = '0;
      triggered_d  = 1'b0;
      prev_match_d = 1'b0;
      state_d      = (pre_len_i == '0) ? WAIT_TRIG : PRE;
    end else begin
      unique case (state_q)
        PRE: begin
          if (take) begin
            pre_cnt_d = pre_inc;
            if (pre_inc == pre_q) state_d = WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          if (force_trig_i || fire) begin
            trig_ptr_d  = take ? wr_ptr_q : wr_ptr_q - 1'b1;
            triggered_d = 1'b1;
            post_cnt_d  = '0;
            state_d     = (post_len == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (take) begin
            post_cnt_d = post_inc;
            if (post_inc == post_len) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      pre_q        <= '0;
      trig_ptr_q   <= '0;
      triggered_q  <= 1'b0;
      prev_match_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      pre_q        <= pre_d;
      trig_ptr_q   <= trig_ptr_d;
      triggered_q  <= triggered_d;
      prev_match_q <= prev_match_d;
    end
  end

  assign busy_o      = capturing;
  assign triggered_o = triggered_q;
  assign done_o      = (state_q == DONE);

  trace_ram #(
    .CH_W       (CH_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (take),
    .waddr_i (wr_ptr_q),
    .wdata_i (probe_i),
    .raddr_i (rd_phys),
    .rdata_o (rd_data_o)
  );

endmodule

// File: tb/tb_bldc_trace_capture.sv
// tb/tb_bldc_trace_capture.sv - scoreboard bench for bldc_trace_capture at DEPTH = 16
module tb_bldc_trace_capture;

  localparam int CH_W = 10;
  localparam int AW   = 4;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            sample_en_i = 1'b0;
  logic [CH_W-1:0] probe_i = '0;
  logic            arm_i = 1'b0;
  logic            abort_i = 1'b0;
  logic            force_trig_i = 1'b0;
  logic [AW-1:0]   pre_len_i = '0;
  logic [CH_W-1:0] trig_val_i = '0;
  logic [CH_W-1:0] trig_mask_i = '0;
  logic            trig_edge_i = 1'b0;
  logic [AW-1:0]   rd_addr_i = '0;
  logic [CH_W-1:0] rd_data_o;
  logic            busy_o, triggered_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CH_W-1:0] hist[$];
  logic [CH_W-1:0] sb[$];

  bldc_trace_capture #(.CH_W(CH_W), .DEPTH_LOG2(AW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .sample_en_i  (sample_en_i),
    .probe_i      (probe_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .force_trig_i (force_trig_i),
    .pre_len_i    (pre_len_i),
    .trig_val_i   (trig_val_i),
    .trig_mask_i  (trig_mask_i),
    .trig_edge_i  (trig_edge_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .busy_o       (busy_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take(input logic [CH_W-1:0] v);
    probe_i = v;
    sample_en_i = 1'b1;
    hist.push_back(v);
    tick();
    sample_en_i = 1'b0;
    tick();
  endtask

  task automatic arm(input logic [AW-1:0] pre, input logic [CH_W-1:0] val,
                     input logic [CH_W-1:0] mask, input logic edge_mode);
    pre_len_i = pre;
    trig_val_i = val;
    trig_mask_i = mask;
    trig_edge_i = edge_mode;
    hist.delete();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic rd_one(input string tag, input int addr, input logic [CH_W-1:0] exp);
    rd_addr_i = AW'(addr);
    sb.push_back(exp);
    tick();
    chk(tag, rd_data_o, sb.pop_front());
  endtask

  // Expected logical slot i is the sample taken pre slots before the trigger, plus i
  task automatic read_all(input string tag, input int trig_idx, input int pre);
    for (int i = 0; i < DEPTH; i++) begin
      rd_one($sformatf("%s_rd%0d", tag, i), i, hist[trig_idx - pre + i]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_trig", triggered_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rdata", rd_data_o, 0);
    rst_i = 1'b0;
    tick();

    // Level trigger on a counting probe, many wraps before the match
    arm(4'd5, 10'h07F, 10'h3FF, 1'b0);
    chk("lvl_busy", busy_o, 1);
    for (int v = 0; v <= 137; v++) begin
      take(CH_W'(v));
      if (v == 126) chk("lvl_pre_trig", triggered_o, 0);
      if (v == 127) chk("lvl_trig", triggered_o, 1);
      if (v == 136) chk("lvl_not_done", done_o, 0);
    end
    chk("lvl_done", done_o, 1);
    chk("lvl_idle_busy", busy_o, 0);
    rd_one("lvl_a5", 5, 10'h07F);
    rd_one("lvl_a0", 0, 10'h07A);
    rd_one("lvl_a15", 15, 10'h089);
    read_all("lvl", 127, 5);

    // Edge mode: bit0 high through PRE must not trigger until a fresh 0->1
    probe_i = 10'h001;
    arm(4'd4, 10'h001, 10'h001, 1'b1);
    for (int k = 0; k <= 18; k++) begin
      take(CH_W'((k << 1) | ((k == 6) ? 0 : 1)));
      if (k == 5) chk("edge_hold_high", triggered_o, 0);
      if (k == 6) chk("edge_low", triggered_o, 0);
      if (k == 7) chk("edge_rise", triggered_o, 1);
      if (k == 17) chk("edge_not_done", done_o, 0);
    end
    chk("edge_done", done_o, 1);
    rd_one("edge_trig_at_pre", 4, 10'h00F);
    read_all("edge", 7, 4);

    // Abort beats arm in the same cycle; triggered is held
    arm_i = 1'b1;
    abort_i = 1'b1;
    tick();
    arm_i = 1'b0;
    abort_i = 1'b0;
    chk("armabort_busy", busy_o, 0);
    chk("armabort_done", done_o, 0);
    chk("armabort_trig_hold", triggered_o, 1);

    // Maximum pre-trigger length: done on the trigger sample itself
    arm(4'hF, 10'h0AA, 10'h3FF, 1'b0);
    for (int k = 0; k < 15; k++) take((k == 3) ? 10'h0AA : CH_W'(10'h100 + k));
    chk("clamp_pre_ignored", triggered_o, 0);
    take(10'h1F0);
    chk("clamp_not_done", done_o, 0);
    take(10'h0AA);
    chk("clamp_done", done_o, 1);
    chk("clamp_trig", triggered_o, 1);
    rd_one("clamp_a15", 15, 10'h0AA);
    read_all("clamp", 16, 15);

    // Force trigger with no pre-trigger window; arm during POST is ignored
    arm(4'd0, 10'h3FF, 10'h3FF, 1'b0);
    chk("force_busy", busy_o, 1);
    for (int k = 0; k < 3; k++) take(CH_W'(10'h010 + k));
    force_trig_i = 1'b1;
    tick();
    force_trig_i = 1'b0;
    chk("force_trig", triggered_o, 1);
    chk("force_not_done", done_o, 0);
    for (int k = 0; k < 15; k++) begin
      if (k == 7) begin
        pre_len_i = 4'd9;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("post_arm_ignored", triggered_o, 1);
      end
      take(CH_W'(10'h020 + k));
      if (k == 13) chk("force_not_done14", done_o, 0);
    end
    chk("force_done", done_o, 1);
    rd_one("force_a0", 0, 10'h012);
    read_all("force", 2, 0);

    // Asynchronous reset in the middle of POST
    arm(4'd2, 10'h000, 10'h000, 1'b0);
    for (int k = 0; k < 5; k++) take(CH_W'(10'h050 + k));
    chk("midpost_busy", busy_o, 1);
    chk("midpost_trig", triggered_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_busy", busy_o, 0);
    chk("async_trig", triggered_o, 0);
    chk("async_done", done_o, 0);
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    take(10'h3AB);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_done", done_o, 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
